// File: rtl/gaussian_rd_engine.sv
// Gaussian input-buffer read engine: fetches buffer 0 as cache lines under credit
// control, streams them tagged to the filter datapath, then posts a DSM completion word.
module gaussian_rd_engine #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int ADDR_W          = 42,
    parameter int DATA_W          = 512,
    parameter int TAG_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       hc_control,
    input  logic [ADDR_W-1:0] hc_dsm_base,
    input  logic [ADDR_W-1:0] hc_buf_addr,
    input  logic [31:0]       hc_buf_size,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    output logic [TAG_W-1:0]  rd_req_tag,
    input  logic              rd_req_almfull,
    input  logic              rd_rsp_valid,
    input  logic [TAG_W-1:0]  rd_rsp_tag,
    input  logic [DATA_W-1:0] rd_rsp_data,
    output logic              wr_req_valid,
    output logic [ADDR_W-1:0] wr_req_addr,
    output logic [DATA_W-1:0] wr_req_data,
    input  logic              wr_req_almfull,
    input  logic              wr_rsp_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);
    // state    | meaning
    // IDLE     | waiting for a start edge
    // READ     | issuing line reads while credits allow
    // DRAIN    | all reads issued, waiting for the last line to be accepted
    // DSM_WR   | waiting for write channel room, then posting the completion word
    // DSM_WAIT | waiting for the completion write acknowledgement
    // DONE     | done held until start is released
    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_DSM_WR, S_DSM_WAIT, S_DONE} state_t;

    localparam int LINES_W = 27;
    localparam int PTR_W   = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    state_t               state, state_nxt;
    logic                 start_q, start_edge;
    logic [32:0]          size_sum;
    logic [LINES_W-1:0]   lines_calc, lines, issued, accepted;
    logic [ADDR_W-1:0]    buf_base, dsm_base;
    logic [CNT_W-1:0]     credits, count;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [TAG_W+DATA_W-1:0] mem [MAX_OUTSTANDING];
    logic                 issue, pop, push, wr_issue;
    logic                 unused_bits;

    assign size_sum    = {1'b0, hc_buf_size} + 33'd63;
    assign lines_calc  = size_sum[32:6];
    assign unused_bits = ^{hc_control[31:1], size_sum[5:0]};
    assign start_edge  = hc_control[0] & ~start_q;

    assign out_valid = (count != '0);
    assign {out_idx, out_data} = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        issue     = 1'b0;
        wr_issue  = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start_edge) state_nxt = (lines_calc != '0) ? S_READ : S_DSM_WR;
            end
            S_READ: begin
                issue = (issued < lines) && (credits != '0) && !rd_req_almfull;
                if (issued == lines) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (accepted == lines) state_nxt = S_DSM_WR;
            S_DSM_WR: begin
                wr_issue = !wr_req_almfull;
                if (wr_issue) state_nxt = S_DSM_WAIT;
            end
            S_DSM_WAIT: if (wr_rsp_valid) state_nxt = S_DONE;
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (!hc_control[0]) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign pop  = out_valid && out_ready;
    // a full FIFO still takes a response when a line leaves in the same cycle
    assign push = rd_rsp_valid && (state == S_READ || state == S_DRAIN) && (count != MAX_CNT || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q      <= 1'b0;
            lines        <= '0;
            buf_base     <= '0;
            dsm_base     <= '0;
            issued       <= '0;
            accepted     <= '0;
            credits      <= '0;
            rd_req_valid <= 1'b0;
            rd_req_addr  <= '0;
            rd_req_tag   <= '0;
            wr_req_valid <= 1'b0;
            wr_req_addr  <= '0;
            wr_req_data  <= '0;
            err          <= 1'b0;
        end else begin
            start_q      <= hc_control[0];
            rd_req_valid <= issue;
            wr_req_valid <= wr_issue;
            if (state == S_IDLE && start_edge) begin
                lines    <= lines_calc;
                buf_base <= hc_buf_addr;
                dsm_base <= hc_dsm_base;
                issued   <= '0;
                accepted <= '0;
                credits  <= MAX_CNT;
            end else begin
                if (issue) begin
                    issued      <= issued + 1'b1;
                    rd_req_addr <= buf_base + ADDR_W'(issued);
                    rd_req_tag  <= TAG_W'(issued);
                end
                if (pop) accepted <= accepted + 1'b1;
                credits <= credits - CNT_W'(issue) + CNT_W'(pop);
            end
            if (wr_issue) begin
                wr_req_addr <= dsm_base;
                wr_req_data <= DATA_W'(32'h1);
            end
            if (rd_rsp_valid && !push) err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {rd_rsp_tag, rd_rsp_data};
    end
endmodule

// File: doc/gaussian_rd_engine.md
Name: gaussian_rd_engine

Overview:
- Downstream consumer of the Gaussian CSR block. Watches the start bit in hc_control and fetches input buffer 0 (line address plus byte size) from host memory as 64-byte cache-line reads.
- Delivers fetched lines as a tagged stream to the filter datapath, using credit-based flow control.
- After the last line is delivered, writes a completion word to the DSM line at hc_dsm_base.

Parameters:
- MAX_OUTSTANDING, 16, maximum lines issued but not yet accepted downstream; also the response FIFO depth. Must be a power of 2, ≥2.
- ADDR_W, 42, cache-line address width.
- DATA_W, 512, line width.
- TAG_W, 16, read-request tag (mdata) width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- hc_control  in  32  bit0 = start; other bits ignored
- hc_dsm_base  in  ADDR_W  DSM line address
- hc_buf_addr  in  ADDR_W  buffer 0 line address
- hc_buf_size  in  32  buffer 0 size in bytes
- rd_req_valid  out  1  read request
- rd_req_addr  out  ADDR_W  line address
- rd_req_tag  out  TAG_W  line index, low TAG_W bits
- rd_req_almfull  in  1  read channel almost full
- rd_rsp_valid  in  1  read response
- rd_rsp_tag  in  TAG_W  echoed tag
- rd_rsp_data  in  DATA_W  line data
- wr_req_valid  out  1  DSM write request
- wr_req_addr  out  ADDR_W  DSM write address
- wr_req_data  out  DATA_W  DSM write data
- wr_req_almfull  in  1  write channel almost full
- wr_rsp_valid  in  1  write acknowledgement
- out_valid  out  1  line available
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  line data
- out_idx  out  TAG_W  line index (tag)
- busy  out  1  engine active
- done  out  1  completion
- err  out  1  sticky protocol error

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0; counters, credits and FIFO cleared. Asserting reset mid-operation aborts everything immediately; late responses arriving afterwards set err.
- lines = (hc_buf_size + 63) >> 6, captured together with hc_buf_addr and hc_dsm_base on the start edge. Later CSR changes are ignored until the next start.
- IDLE: on a 0→1 edge of hc_control[0], go to READ (lines > 0) or DSM_WR (lines == 0). busy=1 in every state except IDLE and DONE.
- READ: rd_req_valid is registered, at most one request per cycle. A request issues when issued < lines, credits > 0 and rd_req_almfull == 0.
  - rd_req_addr = base + issued; rd_req_tag = issued[TAG_W-1:0].
  - When issued == lines, go to DRAIN.
- Credits:
  - Start at MAX_OUTSTANDING.
  - Decrement on request issue; increment on out_valid & out_ready. Both in the same cycle → unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- Response FIFO: depth MAX_OUTSTANDING, first-word fall-through from the register stage.
  - A response written in cycle N is visible on out_valid in cycle N+1.
  - Order is arrival order; responses may return out of order, so out_idx carries the tag.
  - Simultaneous write and read when full is legal.
  - A write into a full FIFO, or rd_rsp_valid outside READ/DRAIN, sets err and the data is dropped.
- out_valid/out_data/out_idx hold stable until out_ready.
- DRAIN: when accepted == lines, go to DSM_WR.
- DSM_WR: wait for wr_req_almfull == 0, then pulse wr_req_valid for one cycle with wr_req_addr = dsm_base and wr_req_data = {DATA_W-32 zeros, 32'h1}. Go to DSM_WAIT.
- DSM_WAIT: on wr_rsp_valid, go to DONE.
- DONE: done=1, busy=0. When hc_control[0]==0, go to IDLE; done clears in the same transition. Holding start at 1 never retriggers.
- err clears only on reset.

Test Plan:
- hc_buf_size=256, addr=0x1000, no backpressure, in-order responses after 5 cycles → requests 0x1000..0x1003 with tags 0..3 on consecutive cycles; 4 output beats; one DSM write to dsm_base with data 1; done=1 after wr_rsp.
- hc_buf_size=65 → exactly 2 reads. hc_buf_size=0 → no reads, DSM write issues directly, done asserts.
- MAX_OUTSTANDING=4, 10 lines, out_ready held 0 → exactly 4 requests then stall. Release one accept per cycle → exactly one new request per accept; total 10 beats.
- Responses returned in tag order 2,0,3,1 → out_idx sequence 2,0,3,1 with matching data; err stays 0.
- rd_req_almfull held 1 for 6 cycles mid-READ → no requests during the hold; issue resumes the cycle after release. wr_req_almfull similarly delays wr_req_valid.
- Reset pulsed mid-DRAIN with 2 responses pending → all outputs 0. A later rd_rsp_valid sets err. A fresh start edge completes normally.
